// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller.
// Collects branch resolutions from two resolve ports into a small FIFO and
// replays them one per cycle as PHT counter-update commands. After reset or
// a flush_tables pulse it sweeps every PHT index with a write-weakly-taken
// command before accepting resolutions again.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   s0_*/s1_*                    resolve ports: valid/ready, pc, taken, mispred
//   flush_tables                 pulse: drop queued updates, re-run init sweep
//   init_busy                    high while the init sweep runs
//   pht_upd_en/_pc/_taken        counter-update command (driven from FIFO head)
//   pht_init_en/_index           init-sweep write command
//   stat_branches/stat_mispreds  saturating update counters, present only when
//                                BP_UPDATE_STATS_EN is defined
module bp_update_ctrl #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [31:0]           s0_pc,
    input  logic                  s0_taken,
    input  logic                  s0_mispred,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [31:0]           s1_pc,
    input  logic                  s1_taken,
    input  logic                  s1_mispred,
    input  logic                  flush_tables,
    output logic                  init_busy,
    output logic                  pht_upd_en,
    output logic [31:0]           pht_upd_pc,
    output logic                  pht_upd_taken,
    output logic                  pht_init_en,
    output logic [INDEX_BITS-1:0] pht_init_index
`ifdef BP_UPDATE_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispreds
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        mispred;
    } upd_entry_t;

    state_t                state, state_n;
    logic [INDEX_BITS-1:0] idx, idx_n;
    logic                  rr_port, rr_port_n;

    upd_entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, fifo_clear;
    upd_entry_t            push_entry, head;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    // State, sweep index and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            idx     <= '0;
            rr_port <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            rr_port <= rr_port_n;
        end
    end

    // Next state, arbitration and command outputs
    always_comb begin
        state_n        = state;
        idx_n          = idx;
        rr_port_n      = rr_port;
        s0_ready       = 1'b0;
        s1_ready       = 1'b0;
        init_busy      = 1'b0;
        pht_init_en    = 1'b0;
        pht_init_index = '0;
        pht_upd_en     = 1'b0;
        pht_upd_pc     = '0;
        pht_upd_taken  = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        fifo_clear     = 1'b0;
        push_entry     = '0;
        unique case (state)
            ST_INIT: begin
                init_busy      = 1'b1;
                pht_init_en    = 1'b1;
                pht_init_index = idx;
                if (flush_tables) begin
                    idx_n = '0;
                end else if (idx == '1) begin
                    idx_n   = '0;
                    state_n = ST_RUN;
                end else begin
                    idx_n = idx + INDEX_BITS'(1);
                end
            end
            ST_RUN: begin
                if (flush_tables) begin
                    // The head is discarded along with the rest of the queue.
                    state_n    = ST_INIT;
                    idx_n      = '0;
                    fifo_clear = 1'b1;
                end else begin
                    if (!fifo_empty) begin
                        pht_upd_en    = 1'b1;
                        pht_upd_pc    = head.pc;
                        pht_upd_taken = head.taken;
                        pop           = 1'b1;
                    end
                    // Occupancy is judged before this cycle's pop: no bypass when full.
                    if (!fifo_full) begin
                        if (s0_valid && s1_valid) begin
                            s0_ready  = ~rr_port;
                            s1_ready  = rr_port;
                            rr_port_n = ~rr_port;
                        end else begin
                            s0_ready = s0_valid;
                            s1_ready = s1_valid;
                        end
                    end
                    push       = s0_ready | s1_ready;
                    push_entry = s0_ready ? '{pc: s0_pc, taken: s0_taken, mispred: s0_mispred}
                                          : '{pc: s1_pc, taken: s1_taken, mispred: s1_mispred};
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    // Queue storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // Queue pointers and occupancy; power-of-two depth wraps pointers naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fifo_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef BP_UPDATE_STATS_EN
    // Saturating statistics; only rst clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispreds <= '0;
        end else if (pop) begin
            if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
            if (head.mispred && stat_mispreds != '1) stat_mispreds <= stat_mispreds + 32'd1;
        end
    end
`else
    // The mispred flag is queued regardless; it only feeds the statistics.
    logic unused_mispred;
    assign unused_mispred = head.mispred;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: directed steps plus random traffic
// checked every cycle against a queue-based reference model.
module tb_bp_update_ctrl;

    localparam int unsigned INDEX_BITS = 6;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          ENTRIES    = 1 << INDEX_BITS;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  s0_valid = 1'b0, s1_valid = 1'b0;
    logic                  s0_ready, s1_ready;
    logic [31:0]           s0_pc = '0, s1_pc = '0;
    logic                  s0_taken = 1'b0, s1_taken = 1'b0;
    logic                  s0_mispred = 1'b0, s1_mispred = 1'b0;
    logic                  flush_tables = 1'b0;
    logic                  init_busy;
    logic                  pht_upd_en;
    logic [31:0]           pht_upd_pc;
    logic                  pht_upd_taken;
    logic                  pht_init_en;
    logic [INDEX_BITS-1:0] pht_init_index;
`ifdef BP_UPDATE_STATS_EN
    logic [31:0]           stat_branches, stat_mispreds;
`endif

    bp_update_ctrl #(.INDEX_BITS(INDEX_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_pc(s0_pc),
        .s0_taken(s0_taken), .s0_mispred(s0_mispred),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_pc(s1_pc),
        .s1_taken(s1_taken), .s1_mispred(s1_mispred),
        .flush_tables(flush_tables), .init_busy(init_busy),
        .pht_upd_en(pht_upd_en), .pht_upd_pc(pht_upd_pc), .pht_upd_taken(pht_upd_taken),
        .pht_init_en(pht_init_en), .pht_init_index(pht_init_index)
`ifdef BP_UPDATE_STATS_EN
        , .stat_branches(stat_branches), .stat_mispreds(stat_mispreds)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: sweep position, pending updates in acceptance order,
    // which port wins the next contested cycle, and update statistics.
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        mispred;
    } req_t;

    req_t   mq[$];
    bit     m_init;
    int     m_idx;
    bit     m_rr;
    longint m_br, m_mp;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_init = 1'b1;
        m_idx  = 0;
        m_rr   = 1'b0;
        m_br   = 0;
        m_mp   = 0;
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // One clock cycle: drive inputs at the falling edge, check, advance the model.
    task automatic step(input bit v0, input bit v1, input logic [31:0] pc0, input logic [31:0] pc1,
                        input bit t0, input bit t1, input bit mp0, input bit mp1, input bit fl);
        bit   full, can, r0, r1, ue;
        req_t h;
        s0_valid = v0;  s1_valid = v1;
        s0_pc = pc0;    s1_pc = pc1;
        s0_taken = t0;  s1_taken = t1;
        s0_mispred = mp0; s1_mispred = mp1;
        flush_tables = fl;
        #1;
        full = (mq.size() == FIFO_DEPTH);
        can  = !m_init && !fl && !full;
        r0   = can && v0 && (!v1 || !m_rr);
        r1   = can && v1 && (!v0 || m_rr);
        ue   = !m_init && !fl && (mq.size() > 0);
        h.pc = '0; h.taken = 1'b0; h.mispred = 1'b0;
        if (mq.size() > 0) h = mq[0];
        check("init_busy", 32'(init_busy), 32'(m_init));
        check("pht_init_en", 32'(pht_init_en), 32'(m_init));
        check("pht_init_index", 32'(pht_init_index), m_init ? 32'(m_idx) : 32'd0);
        check("s0_ready", 32'(s0_ready), 32'(r0));
        check("s1_ready", 32'(s1_ready), 32'(r1));
        check("pht_upd_en", 32'(pht_upd_en), 32'(ue));
        check("pht_upd_pc", pht_upd_pc, ue ? h.pc : 32'd0);
        check("pht_upd_taken", 32'(pht_upd_taken), ue ? 32'(h.taken) : 32'd0);
`ifdef BP_UPDATE_STATS_EN
        check("stat_branches", stat_branches, sat32(m_br));
        check("stat_mispreds", stat_mispreds, sat32(m_mp));
`endif
        @(posedge clk);
        if (m_init) begin
            if (fl) m_idx = 0;
            else if (m_idx == ENTRIES - 1) begin m_init = 1'b0; m_idx = 0; end
            else m_idx++;
        end else if (fl) begin
            mq.delete();
            m_init = 1'b1;
            m_idx  = 0;
        end else begin
            if (ue) begin
                void'(mq.pop_front());
                m_br++;
                if (h.mispred) m_mp++;
            end
            if (r0) mq.push_back('{pc: pc0, taken: t0, mispred: mp0});
            else if (r1) mq.push_back('{pc: pc1, taken: t1, mispred: mp1});
            if (v0 && v1 && (r0 || r1)) m_rr = r0;
        end
        @(negedge clk);
    endtask

    task automatic idle_step(input bit fl);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
    endtask

    task automatic rand_step(input int flush_pct);
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             ($urandom_range(0, 99) < flush_pct));
    endtask

    // Reset asserted at a falling edge; outputs must react before any clock edge.
    task automatic apply_reset();
        s0_valid = 1'b1; s1_valid = 1'b1; flush_tables = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_init_busy", 32'(init_busy), 32'd1);
        check("rst_pht_init_en", 32'(pht_init_en), 32'd1);
        check("rst_pht_init_index", 32'(pht_init_index), 32'd0);
        check("rst_s0_ready", 32'(s0_ready), 32'd0);
        check("rst_s1_ready", 32'(s1_ready), 32'd0);
        check("rst_pht_upd_en", 32'(pht_upd_en), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset();

        // Full sweep after reset release, with traffic present but refused
        for (int i = 0; i < ENTRIES; i++) rand_step(0);
        check("busy_after_sweep", 32'(init_busy), 32'd0);

        // Contested grants alternate starting at port 0
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_step(1'b0);
        idle_step(1'b0);

        // Back-to-back port-0 pushes while the queue drains
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 32'h1000 + 32'(i), 32'd0, 1'(i), 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush with an entry pending, then a complete sweep from index 0
        step(1'b1, 1'b1, 32'hAAA0, 32'hBBB0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < ENTRIES + 2; i++) rand_step(0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) rand_step(2);
        for (int i = 0; i < ENTRIES + 2; i++) rand_step(0);

        // Reset in the middle of a sweep at index 20
        idle_step(1'b1);
        for (int i = 0; i < 200 && !(m_init && m_idx == 20); i++) rand_step(0);
        check("midsweep_index", 32'(pht_init_index), 32'd20);
        apply_reset();
        for (int i = 0; i < ENTRIES + 2; i++) rand_step(0);

        // Random traffic to finish, then drain
        for (int i = 0; i < 300; i++) rand_step(1);
        for (int i = 0; i < ENTRIES + 8; i++) idle_step(1'b0);

`ifdef BP_UPDATE_STATS_EN
        // Statistics hold across a flush
        idle_step(1'b1);
        check("stat_branches_after_flush", stat_branches, sat32(m_br));
        check("stat_mispreds_after_flush", stat_mispreds, sat32(m_mp));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, PHT index width (2^INDEX_BITS entries).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, update-queue entries, power of two, >=2.
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s0_valid/s1_valid  in  1  branch-resolution request, resolve ports 0/1.
REQ-006 SHALL have ports s0_ready/s1_ready  out  1  request accepted this cycle.
REQ-007 SHALL have ports s0_pc/s1_pc  in  32  resolved branch PC.
REQ-008 SHALL have ports s0_taken/s1_taken  in  1  actual outcome.
REQ-009 SHALL have ports s0_mispred/s1_mispred  in  1  prediction was wrong.
REQ-010 SHALL have port flush_tables  in  1  one-cycle pulse requesting PHT re-initialisation.
REQ-011 SHALL have port init_busy  out  1  init sweep in progress.
REQ-012 SHALL have ports pht_upd_en  out  1, pht_upd_pc  out  32, pht_upd_taken  out  1  counter-update command to predictor.
REQ-013 SHALL have ports pht_init_en  out  1, pht_init_index  out  INDEX_BITS  write-weakly-taken command to predictor.

Function
REQ-014 SHALL implement FSM states INIT and RUN; init_busy=1 exactly in INIT.
REQ-015 In INIT, SHALL assert pht_init_en every cycle with pht_init_index counting 0..2^INDEX_BITS-1, one per cycle, then enter RUN the cycle after index 2^INDEX_BITS-1 is issued.
REQ-016 In INIT, s0_ready, s1_ready and pht_upd_en SHALL be 0.
REQ-017 In RUN, SHALL accept at most one request per cycle, and only when the FIFO is not full (no full-bypass on simultaneous pop).
REQ-018 If exactly one port is valid and FIFO not full, that port's ready SHALL be 1.
REQ-019 If both valid and FIFO not full, SHALL grant by round-robin pointer (reset value: port 0); pointer SHALL move to the non-granted port after each contested grant only.
REQ-020 An accepted request SHALL be pushed {pc, taken, mispred} into FIFO at the accepting edge.
REQ-021 In RUN with FIFO non-empty, SHALL drive pht_upd_en=1 with the head entry's pc/taken combinationally from FIFO head, popping at that edge; minimum latency accept-edge to pht_upd_en = 1 cycle.
REQ-022 SHALL preserve acceptance order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 flush_tables in RUN SHALL, at the next edge, discard all FIFO entries, reset the sweep index to 0, and enter INIT; no push occurs in that cycle (readies forced 0).
REQ-024 flush_tables during INIT SHALL restart the sweep at index 0.
REQ-025 pht_upd_pc/pht_upd_taken SHALL be 0 when pht_upd_en=0; pht_init_index SHALL be 0 when pht_init_en=0.

Reset
REQ-026 While rst=1: state=INIT, sweep index=0, FIFO empty, RR pointer=port 0, all statistics 0.
REQ-027 Outputs during reset: init_busy=1, pht_init_en=1, pht_init_index=0, readies=0, pht_upd_en=0.
REQ-028 First sweep SHALL start at index 0 on the first edge after rst deasserts; reset mid-sweep or mid-drain SHALL abort and restart from REQ-026.

Configuration
REQ-029 Macro BP_UPDATE_STATS_EN defined: SHALL add outputs stat_branches  out  32 and stat_mispreds  out  32, incremented on each pht_upd_en pop (mispreds only if head mispred=1), saturating at 0xFFFFFFFF, cleared by rst only (not by flush_tables).
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Release rst with INDEX_BITS=6 -> pht_init_en for 64 cycles, indices 0..63, init_busy falls cycle 65, readies then follow REQ-018.
REQ-032 RUN, s0 and s1 valid together for 4 cycles, pcs 0x100/0x200 -> grants order s0,s1,s0,s1; pht_upd_pc order 0x100,0x200,0x100,0x200.
REQ-033 Hold pht sink busy via 5 back-to-back s0 pushes at FIFO_DEPTH=4 with drain ongoing -> no push when full, no entry lost or duplicated, order preserved across pointer wrap.
REQ-034 flush_tables pulse with 3 entries queued -> entries discarded, no pht_upd_en, full 64-cycle sweep from index 0.
REQ-035 rst asserted mid-sweep at index 20 -> immediate outputs per REQ-027, sweep restarts at 0 after release.
REQ-036 With BP_UPDATE_STATS_EN: 10 updates, 3 mispred -> stat_branches=10, stat_mispreds=3; unchanged by flush_tables.
